// File: rtl/pong_pkg.sv
// Shared definitions for the pong ball controller: sequencer states,
// default screen/paddle geometry and position widths.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_SCORE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int BALL_SIZE_DEF  = 8;
  localparam int PADDLE_W_DEF   = 8;
  localparam int PADDLE_H_DEF   = 48;
  localparam int PADDLE_L_X_DEF = 16;
  localparam int PADDLE_R_X_DEF = 616;

  localparam int H_W     = 10;
  localparam int V_W     = 9;
  localparam int SCORE_W = 4;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_UP    = 1'b0;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] lim);
    if (s >= lim) return lim;
    else          return s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_paddle_hit.sv
// Vertical overlap test between the ball (top row) and one paddle (top row).
module pong_paddle_hit
  import pong_pkg::*;
#(
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int PADDLE_H  = PADDLE_H_DEF
) (
  input  logic [V_W-1:0] ball_v_i,
  input  logic [V_W-1:0] paddle_v_i,
  output logic           overlap_o
);

  localparam int VX = V_W + 1;

  logic [VX-1:0] bv;
  logic [VX-1:0] pv;

  assign bv = {1'b0, ball_v_i};
  assign pv = {1'b0, paddle_v_i};

  // Extra bit keeps v + size and p + height from wrapping near the bottom edge.
  assign overlap_o = ((bv + VX'(BALL_SIZE)) > pv) && (bv < (pv + VX'(PADDLE_H)));

endmodule

// File: rtl/pong_ball_ctrl.sv
// Per-frame pong sequencer: serves, moves and bounces the ball, resolves
// paddle hits and keeps score. All outputs come straight from registers.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int BALL_SIZE    = BALL_SIZE_DEF,
  parameter int STEP         = 2,
  parameter int PADDLE_W     = PADDLE_W_DEF,
  parameter int PADDLE_H     = PADDLE_H_DEF,
  parameter int PADDLE_L_X   = PADDLE_L_X_DEF,
  parameter int PADDLE_R_X   = PADDLE_R_X_DEF,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [V_W-1:0]     paddle_l_pos_v,
  input  logic [V_W-1:0]     paddle_r_pos_v,
  output logic [H_W-1:0]     ball_pos_h,
  output logic [V_W-1:0]     ball_pos_v,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               point,
  output logic               game_over
);

  localparam int HX    = H_W + 1;
  localparam int VX    = V_W + 1;
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [H_W-1:0]     CH      = H_W'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [V_W-1:0]     CV      = V_W'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [HX-1:0]      L_FACE  = HX'(PADDLE_L_X + PADDLE_W);
  localparam logic [HX-1:0]      R_FACE  = HX'(PADDLE_R_X - BALL_SIZE);
  localparam logic [HX-1:0]      H_MAX   = HX'(H_ACTIVE - BALL_SIZE);
  localparam logic [VX-1:0]      V_MAX   = VX'(V_ACTIVE - BALL_SIZE);
  localparam logic [HX-1:0]      STEP_H  = HX'(STEP);
  localparam logic [VX-1:0]      STEP_V  = VX'(STEP);
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [H_W-1:0]     h_q, h_d;
  logic [V_W-1:0]     v_q, v_d;
  logic               dir_h_q, dir_h_d;
  logic               dir_v_q, dir_v_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               scorer_l_q, scorer_l_d;
  logic               point_q, point_d;
  logic               game_over_q, game_over_d;

  logic               hit_l;
  logic               hit_r;
  logic [HX-1:0]      h_ext;
  logic [VX-1:0]      v_ext;
  logic [HX-1:0]      nh_r;
  logic [HX-1:0]      nh_l;
  logic [VX-1:0]      nv_dn;
  logic [VX-1:0]      nv_up;

  assign h_ext = {1'b0, h_q};
  assign v_ext = {1'b0, v_q};
  assign nh_r  = h_ext + STEP_H;
  assign nh_l  = h_ext - STEP_H;
  assign nv_dn = v_ext + STEP_V;
  assign nv_up = v_ext - STEP_V;

  pong_paddle_hit #(.BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H)) u_hit_l (
    .ball_v_i  (v_q),
    .paddle_v_i(paddle_l_pos_v),
    .overlap_o (hit_l)
  );

  pong_paddle_hit #(.BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H)) u_hit_r (
    .ball_v_i  (v_q),
    .paddle_v_i(paddle_r_pos_v),
    .overlap_o (hit_r)
  );

  // Next-state logic for the sequencer and all game registers.
  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    v_d        = v_q;
    dir_h_d    = dir_h_q;
    dir_v_d    = dir_v_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    cnt_d      = cnt_q;
    scorer_l_d = scorer_l_q;
    point_d    = 1'b0;
    case (state_q)
      ST_SERVE: begin
        h_d = CH;
        v_d = CV;
        if (frame_tick) begin
          if (cnt_q == CNT_END) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (dir_v_q == DIR_DOWN) begin
            if (nv_dn >= V_MAX) begin
              v_d     = V_MAX[V_W-1:0];
              dir_v_d = DIR_UP;
            end else begin
              v_d = nv_dn[V_W-1:0];
            end
          end else begin
            if (v_ext < STEP_V) begin
              v_d     = '0;
              dir_v_d = DIR_DOWN;
            end else begin
              v_d = nv_up[V_W-1:0];
            end
          end
          // A face counts only on the frame the ball crosses it, so a miss never retries.
          if (dir_h_q == DIR_RIGHT) begin
            if ((h_ext < R_FACE) && (nh_r >= R_FACE) && hit_r) begin
              h_d     = R_FACE[H_W-1:0];
              dir_h_d = DIR_LEFT;
            end else if (nh_r > H_MAX) begin
              score_l_d  = sat_inc(score_l_q, WIN);
              scorer_l_d = 1'b1;
              point_d    = 1'b1;
              state_d    = ST_SCORE;
            end else begin
              h_d = nh_r[H_W-1:0];
            end
          end else begin
            if ((h_ext > L_FACE) && (nh_l <= L_FACE) && hit_l) begin
              h_d     = L_FACE[H_W-1:0];
              dir_h_d = DIR_RIGHT;
            end else if (h_ext < STEP_H) begin
              score_r_d  = sat_inc(score_r_q, WIN);
              scorer_l_d = 1'b0;
              point_d    = 1'b1;
              state_d    = ST_SCORE;
            end else begin
              h_d = nh_l[H_W-1:0];
            end
          end
        end
      end
      ST_SCORE: begin
        h_d     = CH;
        v_d     = CV;
        dir_v_d = DIR_DOWN;
        cnt_d   = '0;
        // Re-serve toward the player who just conceded.
        dir_h_d = scorer_l_q ? DIR_RIGHT : DIR_LEFT;
        if ((scorer_l_q ? score_l_q : score_r_q) == WIN) state_d = ST_OVER;
        else                                             state_d = ST_SERVE;
      end
      ST_OVER: begin
        h_d = CH;
        v_d = CV;
        if (start) begin
          score_l_d = '0;
          score_r_d = '0;
          dir_h_d   = DIR_RIGHT;
          dir_v_d   = DIR_DOWN;
          cnt_d     = '0;
          state_d   = ST_SERVE;
        end
      end
      default: begin
        state_d = ST_SERVE;
      end
    endcase
    game_over_d = (state_d == ST_OVER);
  end

  // Game state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SERVE;
      h_q         <= CH;
      v_q         <= CV;
      dir_h_q     <= DIR_RIGHT;
      dir_v_q     <= DIR_DOWN;
      score_l_q   <= '0;
      score_r_q   <= '0;
      cnt_q       <= '0;
      scorer_l_q  <= 1'b0;
      point_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      dir_h_q     <= dir_h_d;
      dir_v_q     <= dir_v_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      cnt_q       <= cnt_d;
      scorer_l_q  <= scorer_l_d;
      point_q     <= point_d;
      game_over_q <= game_over_d;
    end
  end

  assign ball_pos_h = h_q;
  assign ball_pos_v = v_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign point      = point_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Scoreboard bench for pong_ball_ctrl: directed frame sequences push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [8:0] paddle_l_pos_v = 9'd150;
  logic [8:0] paddle_r_pos_v = 9'd400;
  logic [9:0] ball_pos_h;
  logic [8:0] ball_pos_v;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       point;
  logic       game_over;

  pong_ball_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start         (start),
    .paddle_l_pos_v(paddle_l_pos_v),
    .paddle_r_pos_v(paddle_r_pos_v),
    .ball_pos_h    (ball_pos_h),
    .ball_pos_v    (ball_pos_v),
    .score_l       (score_l),
    .score_r       (score_r),
    .point         (point),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    string      name;
    logic [9:0] h;
    logic [8:0] v;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       pt;
    logic       go;
    logic       chk_h;
    logic       chk_v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due at this sample point.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    while (q.size() > 0 && (q[0].due <= cyc || done)) begin
      e = q.pop_front();
      checks++;
      if ((e.due != cyc) || done) begin
        failures++;
        $display("FAIL %s expired @cyc %0d (due %0d): expectation never sampled on time",
                 e.name, cyc, e.due);
      end else begin
        ok = (!e.chk_h || ball_pos_h == e.h) && (!e.chk_v || ball_pos_v == e.v) &&
             score_l == e.sl && score_r == e.sr && point == e.pt && game_over == e.go;
        if (!ok) begin
          failures++;
          $display("FAIL %s @cyc %0d: got h=%0d v=%0d sl=%0d sr=%0d point=%0b go=%0b, expected h=%0d v=%0d sl=%0d sr=%0d point=%0b go=%0b",
                   e.name, cyc, ball_pos_h, ball_pos_v, score_l, score_r, point, game_over,
                   e.h, e.v, e.sl, e.sr, e.pt, e.go);
        end
      end
    end
  end

  function automatic exp_t mk(string n, int h, int v, int sl, int sr, bit pt, bit go,
                              bit ch = 1'b1, bit cv = 1'b1);
    exp_t e;
    e.due = 0;   e.name = n;
    e.h = 10'(h); e.v = 9'(v);
    e.sl = 4'(sl); e.sr = 4'(sr);
    e.pt = pt;   e.go = go;
    e.chk_h = ch; e.chk_v = cv;
    return e;
  endfunction

  task automatic push_exp(input int dly, input exp_t e);
    e.due = cyc + dly;
    q.push_back(e);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic tick_chk(input exp_t e);
    push_exp(1, e);
    tick_n(1);
  endtask

  task automatic do_reset(input string n);
    rst = 1'b1;
    push_exp(1, mk(n, 316, 236, 0, 0, 1'b0, 1'b0));
    @(negedge clk);
    checks++;
    if (ball_pos_h !== 10'd316 || ball_pos_v !== 9'd236 || score_l !== 4'd0 ||
        score_r !== 4'd0 || point !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL %s reset state: got h=%0d v=%0d sl=%0d sr=%0d point=%0b go=%0b",
               n, ball_pos_h, ball_pos_v, score_l, score_r, point, game_over);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);

    // Serve, bottom wall, right hit, top wall, left hit.
    paddle_r_pos_v = 9'd400;
    paddle_l_pos_v = 9'd150;
    do_reset("reset");
    tick_n(59);
    tick_chk(mk("serve_hold", 316, 236, 0, 0, 1'b0, 1'b0));
    tick_chk(mk("play1", 318, 238, 0, 0, 1'b0, 1'b0));
    tick_n(116);
    tick_chk(mk("bottom_wall", 552, 472, 0, 0, 1'b0, 1'b0));
    tick_chk(mk("bottom_up", 554, 470, 0, 0, 1'b0, 1'b0));
    tick_n(26);
    tick_chk(mk("r_hit", 608, 416, 0, 0, 1'b0, 1'b0));
    tick_chk(mk("r_hit_back", 606, 414, 0, 0, 1'b0, 1'b0));
    tick_n(206);
    tick_chk(mk("top_wall", 192, 0, 0, 0, 1'b0, 1'b0));
    tick_chk(mk("top_hold", 190, 0, 0, 0, 1'b0, 1'b0));
    tick_chk(mk("top_down", 188, 2, 0, 0, 1'b0, 1'b0));
    tick_n(81);
    tick_chk(mk("l_hit", 24, 166, 0, 0, 1'b0, 1'b0));
    tick_chk(mk("l_hit_back", 26, 168, 0, 0, 1'b0, 1'b0));

    // Right misses until game over, then restart.
    paddle_r_pos_v = 9'd0;
    do_reset("reset_b");
    tick_n(205);
    tick_chk(mk("r_pass", 608, 416, 0, 0, 1'b0, 1'b0));
    tick_n(12);
    push_exp(1, mk("score_l_1", 632, 0, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0));
    push_exp(2, mk("serve_ctr_1", 316, 236, 1, 0, 1'b0, 1'b0));
    tick_n(1);
    for (int k = 2; k <= 9; k++) begin
      tick_n(218);
      push_exp(1, mk($sformatf("score_l_%0d", k), 632, 0, k, 0, 1'b1, 1'b0, 1'b1, 1'b0));
      push_exp(2, mk($sformatf("after_pt_%0d", k), 316, 236, k, 0, 1'b0, k == 9));
      tick_n(1);
    end
    tick_chk(mk("over_hold", 316, 236, 9, 0, 1'b0, 1'b1));
    push_exp(1, mk("restart", 316, 236, 0, 0, 1'b0, 1'b0));
    start = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    tick_n(59);
    tick_chk(mk("serve_again", 316, 236, 0, 0, 1'b0, 1'b0));
    tick_chk(mk("play1_again", 318, 238, 0, 0, 1'b0, 1'b0));

    // Left miss: right player scores, re-serve heads left.
    paddle_r_pos_v = 9'd400;
    paddle_l_pos_v = 9'd300;
    do_reset("reset_c");
    tick_n(510);
    push_exp(1, mk("score_r_1", 0, 0, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0));
    push_exp(2, mk("serve_ctr_r", 316, 236, 0, 1, 1'b0, 1'b0));
    tick_n(1);
    tick_n(60);
    tick_chk(mk("serve_left", 314, 238, 0, 1, 1'b0, 1'b0));

    // Reset in the middle of play.
    do_reset("reset_d");
    tick_n(108);
    tick_chk(mk("pre_rst", 414, 334, 0, 0, 1'b0, 1'b0));
    push_exp(1, mk("mid_rst", 316, 236, 0, 0, 1'b0, 1'b0));
    rst = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    tick_chk(mk("after_rst_serve", 316, 236, 0, 0, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    done = 1'b1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_ball_ctrl.md
# pong_ball_ctrl

Per-frame game sequencer for the VGA pong design. It owns the ball position, its direction and the score. Once per frame it advances the ball, resolves wall and paddle collisions, and counts points. The pixel generator consumes its registered ball/score outputs; paddle positions come from the paddle logic.

## Interface
Parameters:
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- BALL_SIZE, 8, ball edge in pixels (square)
- STEP, 2, pixels moved per frame on each axis
- PADDLE_W, 8, paddle width
- PADDLE_H, 48, paddle height
- PADDLE_L_X, 16, left paddle left column
- PADDLE_R_X, 616, right paddle left column
- SERVE_FRAMES, 60, frames the ball is held before play
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- start  in  1  one-cycle pulse; restarts the game from OVER
- paddle_l_pos_v  in  9  left paddle top row
- paddle_r_pos_v  in  9  right paddle top row
- ball_pos_h  out  10  ball left column
- ball_pos_v  out  9  ball top row
- score_l, score_r  out  4  scores
- point  out  1  one-cycle pulse when a point is scored
- game_over  out  1  high in OVER

## Operation
- States: SERVE, PLAY, SCORE, OVER.
- Ball centre constants: CH = H_ACTIVE/2 − BALL_SIZE/2 (316), CV = V_ACTIVE/2 − BALL_SIZE/2 (236).
- Face constants: L_FACE = PADDLE_L_X + PADDLE_W (24), R_FACE = PADDLE_R_X − BALL_SIZE (608).
- Wall constants: H_MAX = H_ACTIVE − BALL_SIZE (632), V_MAX = V_ACTIVE − BALL_SIZE (472).
- Reset values: state SERVE, ball (CH, CV), dir_h right, dir_v down, scores 0, serve counter 0, point 0, game_over 0.
- SERVE:
  - Ball is held at centre and the serve counter increments on each frame_tick.
  - On the tick where the counter equals SERVE_FRAMES−1, go to PLAY and clear the counter.
- PLAY: on each frame_tick, update both axes from the current registered values.
  - Vertical:
    - nv = v ± STEP.
    - Moving down with nv ≥ V_MAX: v = V_MAX and dir_v goes up.
    - Moving up with v < STEP: v = 0 and dir_v goes down.
  - Paddle hit test uses the current (pre-update) v against the paddle top p:
    - overlap = (v + BALL_SIZE > p) && (v < p + PADDLE_H).
  - Horizontal:
    - nh = h ± STEP.
    - Moving right, h < R_FACE ≤ nh, and overlap with paddle_r: h = R_FACE, dir_h goes left.
    - Moving left, h > L_FACE ≥ nh, and overlap with paddle_l: h = L_FACE, dir_h goes right.
    - Moving right with nh > H_MAX: score_l++, point=1, go to SCORE; h is not updated.
    - Moving left with h < STEP: score_r++, point=1, go to SCORE.
    - Otherwise h = nh.
  - A missed paddle face does not retry on later frames. The ball continues to the wall.
- SCORE (one cycle, no tick needed):
  - Ball returns to (CH, CV).
  - dir_h points toward the player who conceded; dir_v goes down.
  - If the incremented score equals WIN_SCORE, go to OVER; otherwise go to SERVE.
- OVER:
  - Ball is held at centre and game_over is 1; frame_tick is ignored.
  - start clears both scores and goes to SERVE with dir_h right. start is ignored in all other states.
- Width rules:
  - All position arithmetic is done one bit wider, so there is no wrap.
  - Scores saturate at WIN_SCORE; they cannot exceed it.

## Timing
- All outputs are registered.
- State and position change on the clk edge that samples frame_tick=1; they are visible in the next cycle.
- point is high for exactly one cycle: the cycle after the scoring tick.
- The SCORE→SERVE/OVER transition takes one cycle after that.
- Simultaneous start and frame_tick in OVER: start wins.
- frame_tick in SCORE is ignored.
- rst mid-operation: all registers return to reset values at the next edge; rst dominates start and frame_tick.

## Structure
- Shared package pong_pkg holds:
  - the state enum,
  - geometry defaults (H_ACTIVE, V_ACTIVE, BALL_SIZE, paddle sizes and columns),
  - the position width constants.
- One combinational sub-module, pong_paddle_hit, computes `overlap` from (ball_v, paddle_v). It is instantiated twice.

## Test plan
- **Reset and serve:** apply rst → ball (316,236), scores 0, SERVE. After 60 ticks → PLAY. Tick 61 → (318,238).
- **Bottom wall:**
  - PLAY tick 118 → v=472, h=552, dir_v up.
  - Tick 119 → v=470.
- **Right paddle hit:**
  - Set paddle_r_pos_v=400. The tests are not cumulative: run the sequence from reset.
  - PLAY tick 146 (pre-update v=418) → h=608, v=416, dir_h left.
  - Tick 147 → h=606.
- **Right miss:**
  - Set paddle_r_pos_v=0. Tick 146 → h=608, continuing right.
  - Tick 159 → score_l=1 and point pulses 1 cycle.
  - Next cycle → SERVE with ball at (316,236).
- **Game over:**
  - Repeat misses until score_l=9 → game_over=1; further ticks leave the ball at (316,236).
  - Pulse start together with frame_tick → scores 0, SERVE.
- **Reset mid-PLAY:** assert rst at PLAY tick 50 → (316,236), scores 0, SERVE on the next edge.
